// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the bit-counter width helper.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter must index 0..width-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_bit_cell.sv
// One-bit full-subtractor cell: d = x - y - bin, with borrow out.
module sub_bit_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: a - b - borrow_in, one bit per clock,
// LSB first, with results presented alongside a one-cycle done pulse.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero
);

    localparam int           CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             step_d;
    logic             step_bout;
    logic             accept;
    logic             last_step;

    sub_bit_cell u_cell (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (brw),
        .d    (step_d),
        .bout (step_bout)
    );

    // A new request is taken in IDLE and also in DONE (back-to-back).
    assign accept    = start && (state_q != ST_RUN);
    assign last_step = (state_q == ST_RUN) && (cnt == LAST);
    assign res_next  = {step_d, res_sr[WIDTH-1:1]};

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)     state_d = ST_RUN;
            ST_RUN:  if (last_step) state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            brw        <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            zero       <= 1'b0;
        end else begin
            if (accept) begin
                a_sr <= a;
                b_sr <= b;
                brw  <= borrow_in;
                cnt  <= '0;
            end else if (state_q == ST_RUN) begin
                a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                brw    <= step_bout;
                res_sr <= res_next;
                cnt    <= cnt + 1'b1;
            end
            // Visible outputs only move on the edge that enters DONE.
            if (last_step) begin
                diff       <= res_next;
                borrow_out <= step_bout;
                zero       <= (res_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus a random
// sweep at WIDTH=8 and WIDTH=16 against an arithmetic reference model.
module tb_serial_subtractor;

    logic        clk;
    logic        rst_n;

    logic        start8, bin8, busy8, done8, bo8, zero8;
    logic [7:0]  a8, b8, diff8;
    logic        start16, bin16, busy16, done16, bo16, zero16;
    logic [15:0] a16, b16, diff16;

    int n_tests = 0;
    int n_fail  = 0;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start8),
        .a          (a8),
        .b          (b8),
        .borrow_in  (bin8),
        .busy       (busy8),
        .done       (done8),
        .diff       (diff8),
        .borrow_out (bo8),
        .zero       (zero8)
    );

    serial_subtractor #(.WIDTH(16)) u_dut16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start16),
        .a          (a16),
        .b          (b16),
        .borrow_in  (bin16),
        .busy       (busy16),
        .done       (done16),
        .diff       (diff16),
        .borrow_out (bo16),
        .zero       (zero16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, result taken modulo 2^w.
    function automatic void ref_sub(input int w, input logic [15:0] av, input logic [15:0] bv,
                                    input logic bi, output logic [15:0] d, output logic bo);
        longint ai, bl, t;
        ai = longint'(av);
        bl = longint'(bv);
        bo = (ai < bl + longint'(bi));
        t  = ai - bl - longint'(bi);
        if (t < 0) t = t + (longint'(1) << w);
        d  = t[15:0];
    endfunction

    task automatic set_start(input int w, input logic s, input logic [15:0] av,
                             input logic [15:0] bv, input logic bi);
        if (w == 8) begin
            start8 = s; a8 = av[7:0]; b8 = bv[7:0]; bin8 = bi;
        end else begin
            start16 = s; a16 = av; b16 = bv; bin16 = bi;
        end
    endtask

    function automatic void peek(input int w, output logic bz, output logic dn,
                                 output logic [15:0] df, output logic bo, output logic zr);
        if (w == 8) begin
            bz = busy8; dn = done8; df = {8'h00, diff8}; bo = bo8; zr = zero8;
        end else begin
            bz = busy16; dn = done16; df = diff16; bo = bo16; zr = zero16;
        end
    endfunction

    // Call right after the accepting posedge. lat = accepting edge to the
    // edge that raised done; -1 when done never appeared within the bound.
    task automatic wait_done(input int w, input bit clr, output int lat, output int bc);
        logic bz, dn, bo, zr;
        logic [15:0] df;
        lat = -1;
        bc  = 0;
        for (int cyc = 1; cyc <= w + 4; cyc++) begin
            @(negedge clk);
            peek(w, bz, dn, df, bo, zr);
            if (dn) begin
                lat = cyc - 1;
                break;
            end
            if (bz) bc++;
            if (clr) set_start(w, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
        end
    endtask

    task automatic check_result(input string tag, input int w, input logic [15:0] av,
                                input logic [15:0] bv, input logic bi);
        logic bz, dn, bo, zr, ebo;
        logic [15:0] df, ed;
        ref_sub(w, av, bv, bi, ed, ebo);
        peek(w, bz, dn, df, bo, zr);
        check({tag, ".diff"}, 32'(df), 32'(ed));
        check({tag, ".borrow"}, 32'(bo), 32'(ebo));
        check({tag, ".zero"}, 32'(zr), 32'(ed == 16'h0));
    endtask

    task automatic do_op(input string tag, input int w, input logic [15:0] av,
                         input logic [15:0] bv, input logic bi);
        int lat, bc;
        set_start(w, 1'b1, av, bv, bi);
        @(posedge clk);
        wait_done(w, 1'b1, lat, bc);
        check({tag, ".latency"}, 32'(lat), 32'(w));
        check({tag, ".busy_cycles"}, 32'(bc), 32'(w));
        check_result(tag, w, av, bv, bi);
    endtask

    initial begin
        logic bz, dn, bo, zr;
        logic [15:0] df;
        int lat, bc, cnt;
        logic [15:0] ra, rb;
        logic        rbi;

        set_start(8, 1'b0, 16'h0, 16'h0, 1'b0);
        set_start(16, 1'b0, 16'h0, 16'h0, 1'b0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int w = 8; w <= 16; w += 8) begin
            peek(w, bz, dn, df, bo, zr);
            check("reset.busy", 32'(bz), 32'd0);
            check("reset.done", 32'(dn), 32'd0);
            check("reset.diff", 32'(df), 32'd0);
            check("reset.borrow", 32'(bo), 32'd0);
            check("reset.zero", 32'(zr), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        do_op("t1", 8, 16'h5A, 16'h23, 1'b0);
        check("t1.done_pulse", 32'(done8), 32'd1);
        @(negedge clk);
        check("t1.done_once", 32'(done8), 32'd0);

        do_op("t2a", 8, 16'h10, 16'h20, 1'b0);
        do_op("t2b", 8, 16'h00, 16'h00, 1'b1);
        do_op("t2c", 8, 16'hFF, 16'hFF, 1'b1);

        do_op("t3", 8, 16'hFF, 16'hFF, 1'b0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            peek(8, bz, dn, df, bo, zr);
            if (df != 16'h0 || bo != 1'b0 || zr != 1'b1 || dn || bz) cnt++;
        end
        check("t3.hold", 32'(cnt), 32'd0);

        // Start held high through RUN must be ignored; DONE-cycle start is taken.
        set_start(8, 1'b1, 16'h81, 16'h01, 1'b0);
        @(posedge clk);
        @(negedge clk);
        set_start(8, 1'b1, 16'h00, 16'h55, 1'b0);
        wait_done(8, 1'b0, lat, bc);
        check("t4a.latency", 32'(lat + 1), 32'd8);
        check_result("t4a", 8, 16'h81, 16'h01, 1'b0);
        set_start(8, 1'b1, 16'h03, 16'h05, 1'b0);
        @(posedge clk);
        wait_done(8, 1'b1, lat, bc);
        check("t4b.latency", 32'(lat), 32'd8);
        check("t4b.busy_cycles", 32'(bc), 32'd8);
        check_result("t4b", 8, 16'h03, 16'h05, 1'b0);

        // Asynchronous abort after the third bit step.
        set_start(8, 1'b1, 16'h5A, 16'h23, 1'b0);
        @(posedge clk);
        @(negedge clk);
        set_start(8, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        peek(8, bz, dn, df, bo, zr);
        check("t5.busy", 32'(bz), 32'd0);
        check("t5.done", 32'(dn), 32'd0);
        check("t5.diff", 32'(df), 32'd0);
        check("t5.borrow", 32'(bo), 32'd0);
        check("t5.zero", 32'(zr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8 || busy8) cnt++;
        end
        check("t5.no_done", 32'(cnt), 32'd0);
        do_op("t5b", 8, 16'h09, 16'h04, 1'b0);

        for (int w = 8; w <= 16; w += 8) begin
            for (int i = 0; i < 500; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                ra  = 16'($urandom);
                rb  = 16'($urandom);
                rbi = 1'($urandom);
                if (w == 8) begin
                    ra = ra & 16'h00FF;
                    rb = rb & 16'h00FF;
                end
                do_op((w == 8) ? "rnd8" : "rnd16", w, ra, rb, rbi);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
